// File: rtl/trig_emulator.sv
// trig_emulator
//
// Emulated beam trigger source. While enabled it produces spills of evenly
// spaced trigger pulses on trigemu, framed by spillgate, with a programmable
// pause between spills. All timing fields are captured into shadow registers
// at each spill start, so CPU writes only affect the next spill.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   enable     - run request (level)
//   period     - clocks from one pulse rising edge to the next
//   pulsewidth - trigemu high time in clocks (0 is treated as 1)
//   spillcnt   - pulses per spill
//   pausetime  - clocks between spills (0 is treated as 1)
//   trigemu    - emulated trigger pulse (registered)
//   spillgate  - high for the duration of a spill
//   trigcount  - pulses issued in the current spill
//   busy       - high whenever the emulator is not idle
//
// Build option:
//   TRIGEMU_JITTER_EN - when defined, each inter-pulse interval is extended by
//   the low nibble of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   that advances once per pulse. When undefined no LFSR logic exists.

module trig_emulator #(
    parameter int PERIOD_W = 16,
    parameter int PAUSE_W  = 24,
    parameter int PW_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PW_W-1:0]     pulsewidth,
    input  logic [PERIOD_W-1:0] spillcnt,
    input  logic [PAUSE_W-1:0]  pausetime,
    output logic                trigemu,
    output logic                spillgate,
    output logic [PERIOD_W-1:0] trigcount,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SPILL = 2'd1;
    localparam logic [1:0] TAIL  = 2'd2;
    localparam logic [1:0] PAUSE = 2'd3;

    // One extra bit so a jittered interval (period + 15) cannot overflow.
    localparam int TICK_W = PERIOD_W + 1;

    logic [1:0]          state;
    logic                lead;      // first clock of SPILL after leaving IDLE
    logic [PW_W-1:0]     pw_s;
    logic [TICK_W-1:0]   per_s;
    logic [PERIOD_W-1:0] cnt_s;
    logic [PAUSE_W-1:0]  pause_s;
    logic [TICK_W-1:0]   tick;      // position inside the current interval
    logic [TICK_W-1:0]   intv;      // length of the current interval
    logic [PAUSE_W-1:0]  pcnt;

    logic [PW_W-1:0]     pw_eff;
    logic [TICK_W-1:0]   per_eff;
    logic [PAUSE_W-1:0]  pause_eff;
    logic                pause_done;
    logic                load;
    logic                stop;
    logic                pulse_start;

    // Clamped timing values computed from the live register inputs.
    always_comb begin
        pw_eff    = (pulsewidth == '0) ? PW_W'(1) : pulsewidth;
        per_eff   = (TICK_W'(period) > TICK_W'(pw_eff)) ? TICK_W'(period)
                                                        : TICK_W'(pw_eff) + TICK_W'(1);
        pause_eff = (pausetime == '0) ? PAUSE_W'(1) : pausetime;
    end

    always_comb begin
        pause_done  = (state == PAUSE) && (pcnt == pause_s - PAUSE_W'(1));
        load        = ((state == IDLE) || pause_done) && enable;
        // With enable gone, a running pulse is allowed to finish its full
        // width; the spill ends on the clock the pulse drops, or at once if
        // the line is already low.
        stop        = !enable && (!trigemu || (tick == TICK_W'(pw_s)));
        pulse_start = (state == SPILL) && !lead && !stop &&
                      (tick == '0) && (trigcount != cnt_s);
    end

    // Shadow registers: captured only when a spill is about to start.
    always_ff @(posedge clk) begin
        if (reset) begin
            pw_s    <= '0;
            per_s   <= '0;
            cnt_s   <= '0;
            pause_s <= '0;
        end else if (load) begin
            pw_s    <= pw_eff;
            per_s   <= per_eff;
            cnt_s   <= spillcnt;
            pause_s <= pause_eff;
        end
    end

`ifdef TRIGEMU_JITTER_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // The interval following a pulse is fixed when that pulse starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
            intv <= '0;
        end else if (pulse_start) begin
            intv <= per_s + TICK_W'(lfsr[3:0]);
            lfsr <= lfsr_next;
        end
    end
`else
    assign intv = per_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lead      <= 1'b0;
            trigemu   <= 1'b0;
            spillgate <= 1'b0;
            busy      <= 1'b0;
            trigcount <= '0;
            tick      <= '0;
            pcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= SPILL;
                        lead      <= 1'b1;
                        tick      <= '0;
                        trigcount <= '0;
                    end
                end
                SPILL: begin
                    if (lead) begin
                        lead      <= 1'b0;
                        spillgate <= 1'b1;
                        busy      <= 1'b1;
                    end else if (stop) begin
                        trigemu   <= 1'b0;
                        spillgate <= 1'b0;
                        state     <= TAIL;
                    end else if (tick == '0) begin
                        // Interval boundary: either issue the next pulse or,
                        // with the count reached, close the spill.
                        if (pulse_start) begin
                            trigemu   <= 1'b1;
                            trigcount <= trigcount + PERIOD_W'(1);
                            tick      <= TICK_W'(1);
                        end else begin
                            spillgate <= 1'b0;
                            state     <= TAIL;
                        end
                    end else begin
                        if (tick == TICK_W'(pw_s)) begin
                            trigemu <= 1'b0;
                        end
                        tick <= (tick == intv - TICK_W'(1)) ? '0 : tick + TICK_W'(1);
                    end
                end
                TAIL: begin
                    state <= PAUSE;
                    pcnt  <= '0;
                end
                PAUSE: begin
                    if (pause_done) begin
                        pcnt      <= '0;
                        trigcount <= '0;
                        if (enable) begin
                            state     <= SPILL;
                            spillgate <= 1'b1;
                            tick      <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pcnt <= pcnt + PAUSE_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_emulator.sv
// tb_trig_emulator
//
// Scoreboard bench for trig_emulator. Expected output transitions of trigemu,
// spillgate and busy are generated from the stimulus parameters and queued
// by clock edge; a negedge monitor pops and compares each observed transition,
// and compares trigcount on every trigemu rising edge.

module tb_trig_emulator;

    localparam int PERIOD_W = 16;
    localparam int PAUSE_W  = 24;
    localparam int PW_W     = 8;
    localparam int SIG_TRIG = 0;
    localparam int SIG_GATE = 1;
    localparam int SIG_BUSY = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic [PW_W-1:0]     pulsewidth;
    logic [PERIOD_W-1:0] spillcnt;
    logic [PAUSE_W-1:0]  pausetime;
    logic                trigemu;
    logic                spillgate;
    logic [PERIOD_W-1:0] trigcount;
    logic                busy;

    trig_emulator #(
        .PERIOD_W (PERIOD_W),
        .PAUSE_W  (PAUSE_W),
        .PW_W     (PW_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .pulsewidth (pulsewidth),
        .spillcnt   (spillcnt),
        .pausetime  (pausetime),
        .trigemu    (trigemu),
        .spillgate  (spillgate),
        .trigcount  (trigcount),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint      ev_q[$];
    int          tc_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    bit          mon_en = 1'b0;
    logic        p_trig, p_gate, p_busy;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Event key: edge number, signal id and new level packed into one value.
    task automatic push_ev(input int c, input int sig, input int val);
        ev_q.push_back(longint'(c) * 8 + longint'(sig * 2 + val));
        ev_q.sort();
    endtask

    task automatic ev_seen(input int sig, input logic val);
        longint key;
        key = longint'(cyc) * 8 + longint'(sig * 2 + int'(val));
        if (ev_q.size() == 0) check_val("unexpected_event", key, 0);
        else check_val("event", key, ev_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (trigemu !== p_trig) ev_seen(SIG_TRIG, trigemu);
            if (spillgate !== p_gate) ev_seen(SIG_GATE, spillgate);
            if (busy !== p_busy) ev_seen(SIG_BUSY, busy);
            if (trigemu === 1'b1 && p_trig === 1'b0) begin
                if (tc_q.size() == 0) check_val("trigcount_extra", longint'(trigcount), 0);
                else check_val("trigcount_at_pulse", longint'(trigcount), longint'(tc_q.pop_front()));
            end
        end
        p_trig = trigemu;
        p_gate = spillgate;
        p_busy = busy;
    end

    // Returns 1 ns after edge c, so inputs set next are sampled at edge c+1.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected events of one spill whose spillgate rises at edge e. With cut>0
    // enable is dropped right after the cut-th pulse starts.
    task automatic gen_spill(input int e, input int per, input int pw, input int cnt,
                             input int cut, output int t_tail, output int t_last);
        int pw_e, per_e, t, n;
        pw_e   = (pw == 0) ? 1 : pw;
        per_e  = (per > pw_e) ? per : pw_e + 1;
        n      = (cut > 0) ? cut : cnt;
        t      = e + 1;
        t_last = -1;
        push_ev(e, SIG_GATE, 1);
        for (int i = 0; i < n; i++) begin
            int iv;
            iv = per_e;
`ifdef TRIGEMU_JITTER_EN
            iv     = per_e + int'(m_lfsr[3:0]);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            push_ev(t, SIG_TRIG, 1);
            push_ev(t + pw_e, SIG_TRIG, 0);
            tc_q.push_back(i + 1);
            t_last = t;
            t      = t + iv;
        end
        t_tail = (cut > 0) ? t_last + pw_e : t;
        push_ev(t_tail, SIG_GATE, 0);
    endtask

    task automatic set_regs(input int per, input int pw, input int cnt, input int pause);
        period     = PERIOD_W'(per);
        pulsewidth = PW_W'(pw);
        spillcnt   = PERIOD_W'(cnt);
        pausetime  = PAUSE_W'(pause);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ev_q.size() != 0 || tc_q.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("pending_events", longint'(ev_q.size()), 0);
        check_val("pending_trigcount", longint'(tc_q.size()), 0);
        ev_q.delete();
        tc_q.delete();
        wait_cyc(cyc + 4);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        wait_cyc(cyc + 2);
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        wait_cyc(cyc + 1);
    endtask

    // One spill from IDLE, enable dropped during the pause, back to IDLE.
    task automatic one_spill(input int per, input int pw, input int cnt, input int pause);
        int n, tt, tl, ps;
        set_regs(per, pw, cnt, pause);
        n      = cyc + 1;
        enable = 1'b1;
        ps     = (pause == 0) ? 1 : pause;
        push_ev(n + 1, SIG_BUSY, 1);
        gen_spill(n + 1, per, pw, cnt, 0, tt, tl);
        push_ev(tt + 1 + ps, SIG_BUSY, 0);
        wait_cyc(tt + 1);
        check_val("trigcount_final", longint'(trigcount), longint'(cnt));
        enable = 1'b0;
        wait_cyc(tt + 1 + ps + 2);
        check_val("trigcount_idle", longint'(trigcount), 0);
        drain();
    endtask

    initial begin
        int n, t1, t2, tl, e;
        reset  = 1'b1;
        enable = 1'b0;
        set_regs(0, 0, 0, 0);
        wait_cyc(3);
        reset = 1'b0;
        check_val("reset_trigemu", longint'(trigemu), 0);
        check_val("reset_spillgate", longint'(spillgate), 0);
        check_val("reset_busy", longint'(busy), 0);
        check_val("reset_trigcount", longint'(trigcount), 0);
        mon_en = 1'b1;
        wait_cyc(cyc + 2);

        // Basic spill twice, inputs changed mid-spill must not matter.
        set_regs(10, 3, 4, 20);
        n      = cyc + 1;
        enable = 1'b1;
        push_ev(n + 1, SIG_BUSY, 1);
        gen_spill(n + 1, 10, 3, 4, 0, t1, tl);
        gen_spill(t1 + 21, 10, 3, 4, 0, t2, tl);
        push_ev(t2 + 21, SIG_BUSY, 0);
        wait_cyc(t1 + 1);
        check_val("basic_tail_trigcount", longint'(trigcount), 4);
        wait_cyc(t1 + 23);
        set_regs(3, 1, 2, 2);
        wait_cyc(t2 + 1);
        enable = 1'b0;
        wait_cyc(t2 + 23);
        check_val("basic_idle_trigcount", longint'(trigcount), 0);
        drain();

        // Clamping: per = pw+1, and pulsewidth 0 gives 1-clock pulses.
        one_spill(2, 5, 3, 4);
        one_spill(2, 0, 3, 4);

        // Mid-spill disable after the 3rd pulse starts.
        set_regs(10, 4, 100, 20);
        n      = cyc + 1;
        enable = 1'b1;
        push_ev(n + 1, SIG_BUSY, 1);
        gen_spill(n + 1, 10, 4, 100, 3, t1, tl);
        push_ev(t1 + 21, SIG_BUSY, 0);
        wait_cyc(tl);
        enable = 1'b0;
        wait_cyc(t1 + 2);
        check_val("disable_trigcount", longint'(trigcount), 3);
        wait_cyc(t1 + 23);
        check_val("disable_busy", longint'(busy), 0);
        drain();

        // Zero count: 1-clock spillgate, repeating every 7 clocks.
        set_regs(10, 3, 0, 5);
        n      = cyc + 1;
        enable = 1'b1;
        push_ev(n + 1, SIG_BUSY, 1);
        e  = n + 1;
        t1 = e;
        for (int k = 0; k < 3; k++) begin
            gen_spill(e, 10, 3, 0, 0, t1, tl);
            e = t1 + 6;
        end
        push_ev(e, SIG_BUSY, 0);
        wait_cyc(t1 + 1);
        enable = 1'b0;
        wait_cyc(e + 2);
        drain();

        // Reset on the 2nd clock of a pulse, then a clean restart.
        set_regs(10, 3, 4, 20);
        n      = cyc + 1;
        enable = 1'b1;
        push_ev(n + 1, SIG_GATE, 1);
        push_ev(n + 1, SIG_BUSY, 1);
        push_ev(n + 2, SIG_TRIG, 1);
        tc_q.push_back(1);
        push_ev(n + 3, SIG_TRIG, 0);
        push_ev(n + 3, SIG_GATE, 0);
        push_ev(n + 3, SIG_BUSY, 0);
        wait_cyc(n + 2);
        reset  = 1'b1;
        enable = 1'b0;
        wait_cyc(n + 3);
        check_val("midreset_trigemu", longint'(trigemu), 0);
        check_val("midreset_spillgate", longint'(spillgate), 0);
        check_val("midreset_busy", longint'(busy), 0);
        check_val("midreset_trigcount", longint'(trigcount), 0);
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        drain();
        one_spill(10, 3, 4, 20);

        // Longer spill, repeated after reset: identical sequence both times.
        do_reset();
        one_spill(10, 3, 8, 20);
        do_reset();
        one_spill(10, 3, 8, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
